// File: rtl/clint_timer_pkg.sv
// Shared widths, default register addresses and the address-decode record
// used by the CLINT machine timer.
package clint_timer_pkg;

   localparam int BUS_64 = 64;
   localparam int BUS_8  = 8;

   localparam logic [BUS_64-1:0] CLINT_MTIME_ADDR    = 64'h0000_0000_0200_BFF8;
   localparam logic [BUS_64-1:0] CLINT_MTIMECMP_ADDR = 64'h0000_0000_0200_4000;

   typedef logic [BUS_64-1:0] word_t;
   typedef logic [BUS_8-1:0]  mask_t;

   typedef struct packed {
      logic hit_time;
      logic hit_cmp;
      logic err;
   } decode_t;

endpackage

// File: rtl/clint_timer_if.sv
// Single-beat MMIO request/response channel between the LSU and the timer.
interface clint_timer_if;
   import clint_timer_pkg::*;

   logic  req_valid;
   logic  req_ready;
   word_t req_addr;
   logic  req_wen;
   word_t req_wdata;
   mask_t req_wmask;
   logic  resp_valid;
   logic  resp_ready;
   word_t resp_rdata;
   logic  resp_err;

   modport master (
      output req_valid, req_addr, req_wen, req_wdata, req_wmask, resp_ready,
      input  req_ready, resp_valid, resp_rdata, resp_err
   );

   modport slave (
      input  req_valid, req_addr, req_wen, req_wdata, req_wmask, resp_ready,
      output req_ready, resp_valid, resp_rdata, resp_err
   );

endinterface

// File: rtl/clint_prescaler.sv
// Free-running divider: pulses tick once every TICK_DIV clock cycles.
module clint_prescaler #(
   parameter int TICK_DIV = 4
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);

   localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

   if (TICK_DIV < 1 || TICK_DIV > 256) begin : g_bad_div
      $error("clint_prescaler: TICK_DIV must be in 1..256");
   end

   logic [CNT_W-1:0] div_cnt;

   assign tick = (div_cnt == LAST);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         div_cnt <= '0;
      end else if (tick) begin
         div_cnt <= '0;
      end else begin
         div_cnt <= div_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/clint_timer.sv
// CLINT machine timer: mtime/mtimecmp registers behind a single-beat MMIO
// responder, with the registered machine timer interrupt pending bit.
module clint_timer
   import clint_timer_pkg::*;
#(
   parameter int          TICK_DIV      = 4,
   parameter logic [63:0] BASE_MTIMECMP = CLINT_MTIMECMP_ADDR,
   parameter logic [63:0] BASE_MTIME    = CLINT_MTIME_ADDR
) (
   input  logic         clk,
   input  logic         rst,
   clint_timer_if.slave bus,
   output logic         mtip
);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RESP = 1'b1;

   logic [0:0] state;
   logic       tick;
   logic       accept;
   logic       wr_time;
   logic       wr_cmp;
   decode_t    dec;
   word_t      mtime;
   word_t      mtimecmp;
   word_t      mtime_next;
   word_t      mtimecmp_next;
   word_t      rd_val;

   function automatic word_t merge_bytes(input word_t old_val, input word_t new_val,
                                         input mask_t mask);
      word_t res;
      for (int i = 0; i < BUS_8; i++) begin
         res[8*i +: 8] = mask[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
      end
      return res;
   endfunction

   clint_prescaler #(
      .TICK_DIV (TICK_DIV)
   ) u_prescaler (
      .clk  (clk),
      .rst  (rst),
      .tick (tick)
   );

   always_comb begin
      dec          = '0;
      dec.hit_time = (bus.req_addr == BASE_MTIME);
      dec.hit_cmp  = (bus.req_addr == BASE_MTIMECMP);
      dec.err      = (bus.req_addr[2:0] != 3'b000) || !(dec.hit_time || dec.hit_cmp);
   end

   assign accept = (state == ST_IDLE) && bus.req_valid;

   // An all-zero mask is a pure no-op, so it must not suppress the tick either.
   assign wr_time = accept && bus.req_wen && !dec.err && dec.hit_time && (bus.req_wmask != '0);
   assign wr_cmp  = accept && bus.req_wen && !dec.err && dec.hit_cmp  && (bus.req_wmask != '0);

   // Software write to mtime overrides the tick; unmasked bytes keep the pre-tick value.
   always_comb begin
      mtime_next = mtime;
      if (wr_time) begin
         mtime_next = merge_bytes(mtime, bus.req_wdata, bus.req_wmask);
      end else if (tick) begin
         mtime_next = mtime + 64'd1;
      end
   end

   always_comb begin
      mtimecmp_next = mtimecmp;
      if (wr_cmp) begin
         mtimecmp_next = merge_bytes(mtimecmp, bus.req_wdata, bus.req_wmask);
      end
   end

   // Reads return the value held before this cycle's tick or write.
   always_comb begin
      rd_val = '0;
      if (!bus.req_wen && !dec.err) begin
         rd_val = dec.hit_time ? mtime : mtimecmp;
      end
   end

   assign bus.req_ready = (state == ST_IDLE);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mtime    <= '0;
         mtimecmp <= '1;
         mtip     <= 1'b0;
      end else begin
         mtime    <= mtime_next;
         mtimecmp <= mtimecmp_next;
         mtip     <= (mtime_next >= mtimecmp_next);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state          <= ST_IDLE;
         bus.resp_valid <= 1'b0;
         bus.resp_rdata <= '0;
         bus.resp_err   <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (bus.req_valid) begin
                  state          <= ST_RESP;
                  bus.resp_valid <= 1'b1;
                  bus.resp_rdata <= rd_val;
                  bus.resp_err   <= dec.err;
               end
            end
            ST_RESP: begin
               if (bus.resp_ready) begin
                  state          <= ST_IDLE;
                  bus.resp_valid <= 1'b0;
               end
            end
            default: begin
               state          <= ST_IDLE;
               bus.resp_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule
